vme_slave_responder: RTL and testbench
======================================

VME_SLAVE_RESPONDER -- requirements
Module: vme_slave_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h20: compared against latched A23..A16 after masking.
REQ-002 SHALL have parameter ADDR_MASK, default 8'hF0: bits of A23..A16 that take part in the decode.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: local-ack timeout limit in clocks, 8-bit range.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports as follows.
- clock  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- vme_as  in  1  VME address strobe, active-low.
- vme_ds  in  2  VME data strobes [1]=DS1, [0]=DS0, active-low.
- vme_lword  in  1  active-low long-word flag.
- vme_write  in  1  active-low write flag.
- vme_address_mod  in  6  VME address modifier.
- vme_address  in  24  A23..A1, bit 0 ignored.
- vme_dtack  out  1  driven 0/1 when owned, Z otherwise.
- vme_berr  out  1  driven 0/1 when owned, Z otherwise.
- data_oe  out  1  active-low data transceiver enable.
- data_dir  out  1  1=DIR_IN (VME to local), 0=DIR_OUT.
- local_req  out  1  active-high local access request.
- local_write  out  1  active-high write.
- local_address  out  24  latched byte address.
- local_size  out  2  00=long, 01=byte, 10=word.
- local_ack  in  1  active-high local access complete.
- local_err  in  1  active-high local access fault.

Function
REQ-006 SHALL pass vme_as and vme_ds through 2-flop synchronizers; all decisions use the synchronized values, giving 2-cycle input latency.
REQ-007 SHALL implement states IDLE, DECODE, ACCESS, RESPOND, RELEASE and IGNORE; any other encoding SHALL go to IDLE.
REQ-008 IDLE: on synced AS active, SHALL latch address, AM, lword and write, then go to DECODE.
REQ-009 DECODE: selected when AM is one of 39/3A/3D/3E and (A23..A16 & ADDR_MASK) == (BASE_ADDR & ADDR_MASK).
- Not selected: SHALL go to IGNORE.
- Selected: SHALL wait for any synced DS active; on that cycle go to ACCESS with local_req=1 and data_oe=0.
- data_dir SHALL be DIR_IN for a write, DIR_OUT for a read.
REQ-010 Size and address decode SHALL be:
- lword active: local_size=00 and address[1:0]=00.
- Both DS active: local_size=10 and address[0]=0.
- DS0 only: local_size=01 and address[0]=1.
- DS1 only: local_size=01 and address[0]=0.
REQ-011 ACCESS: on local_ack, SHALL go to RESPOND, drop local_req, and drive vme_dtack=0.
REQ-012 ACCESS: on local_err, SHALL do the same with vme_berr=0 instead.
REQ-013 If local_ack and local_err are asserted together, local_err SHALL win.
REQ-014 ACCESS: if synced AS goes inactive before ack, SHALL abort the access (local_req=0, data_oe=1) and go to RELEASE without asserting dtack or berr.
REQ-015 RESPOND: once both synced DS are inactive, SHALL drive vme_dtack=1 and vme_berr=1 for one cycle, set data_oe=1, and go to RELEASE.
REQ-016 RELEASE: SHALL tri-state vme_dtack and vme_berr, and go to IDLE once synced AS is inactive.
REQ-017 IGNORE: SHALL keep all bus outputs Z and inactive, and return to IDLE on synced AS inactive.
REQ-018 A new cycle SHALL only begin from IDLE, so an AS that stays low across cycles is never answered twice.

Reset
REQ-019 While reset=0, all outputs SHALL take these values regardless of state, including mid-access: state=IDLE, vme_dtack=Z, vme_berr=Z, data_oe=1, data_dir=DIR_IN, local_req=0, local_write=0, local_address=0, local_size=00, synchronizers=1, timeout counter=0.

Configuration
REQ-020 With VME_SLAVE_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to ACCESS.
- After TIMEOUT_CYCLES clocks without ack or err, the block SHALL behave exactly as for local_err.
REQ-021 Without VME_SLAVE_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait indefinitely.

Verification
REQ-022 A24 supervisor data long read:
- Stimulus: AM=3D, A=0x20_1234, lword=0, DS=00; local_ack after 3 cycles.
- Response: local_address=0x201234, local_size=00, data_dir=DIR_OUT, dtack=0, then dtack=1 for one cycle after DS=11, then Z.
REQ-023 Byte write:
- Stimulus: AM=39, A=0x2F_0010, DS=10.
- Response: local_write=1, local_size=01, local_address=0x2F0011, data_dir=DIR_IN.
REQ-024 Unselected cycle:
- Stimulus: A=0x30_0000, or AM=0x09.
- Response: IGNORE state, local_req never asserted, dtack and berr stay Z.
REQ-025 Error handling:
- local_err with local_ack in the same cycle -> berr=0 and dtack stays Z.
- With VME_SLAVE_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> berr=0 four cycles after ACCESS entry.
REQ-026 Reset and abort:
- reset=0 during ACCESS -> next edge-independent outputs at reset values.
- AS released during ACCESS -> local_req=0 and no dtack.

Source files
------------

// File: rtl/vme_slave_responder.sv
// VME A24 slave bus responder: decodes a bus cycle, hands it to a local access port and answers with DTACK/BERR.
// Optional local-access timeout is enabled by defining VME_SLAVE_TIMEOUT_EN.
module vme_slave_responder #(
  parameter logic [7:0]  BASE_ADDR      = 8'h20,
  parameter logic [7:0]  ADDR_MASK      = 8'hF0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vme_as,
  input  logic [1:0]  vme_ds,
  input  logic        vme_lword,
  input  logic        vme_write,
  input  logic [5:0]  vme_address_mod,
  input  logic [23:0] vme_address,
  output logic        vme_dtack,
  output logic        vme_berr,
  output logic        data_oe,
  output logic        data_dir,
  output logic        local_req,
  output logic        local_write,
  output logic [23:0] local_address,
  output logic [1:0]  local_size,
  input  logic        local_ack,
  input  logic        local_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_ACCESS  = 3'd2,
    S_RESPOND = 3'd3,
    S_RELEASE = 3'd4,
    S_IGNORE  = 3'd5
  } state_t;

  localparam logic [1:0] SZ_LONG = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      r_state, w_state_nx;
  logic        r_as_p1, r_as_p2;
  logic [1:0]  r_ds_p1, r_ds_p2;
  logic [23:1] r_addr;
  logic [5:0]  r_am;
  logic        r_lword, r_write;
  logic        r_dtack, r_dtack_oe, r_berr, r_berr_oe;
  logic        r_data_oe, r_data_dir, r_local_req, r_local_write;
  logic [23:0] r_local_address;
  logic [1:0]  r_local_size;

  logic        w_latch, w_am_ok, w_sel, w_timeout;
  logic        w_dtack, w_dtack_oe, w_berr, w_berr_oe;
  logic        w_data_oe, w_data_dir, w_local_req, w_local_write;
  logic [23:0] w_local_address;
  logic [1:0]  w_local_size;
  logic        w_unused_a0;

  assign w_unused_a0 = vme_address[0];

  assign w_am_ok = (r_am == 6'h39) || (r_am == 6'h3A) || (r_am == 6'h3D) || (r_am == 6'h3E);
  assign w_sel   = w_am_ok && ((r_addr[23:16] & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

`ifdef VME_SLAVE_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_to_cnt;

  // Counter idles at zero outside ACCESS, so it restarts on every ACCESS entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   r_to_cnt <= '0;
    else if (r_state != S_ACCESS) r_to_cnt <= '0;
    else                          r_to_cnt <= r_to_cnt + 8'd1;
  end

  assign w_timeout = (r_state == S_ACCESS) && (r_to_cnt == TO_LAST);
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nx      = r_state;
    w_latch         = 1'b0;
    w_dtack         = r_dtack;
    w_dtack_oe      = r_dtack_oe;
    w_berr          = r_berr;
    w_berr_oe       = r_berr_oe;
    w_data_oe       = r_data_oe;
    w_data_dir      = r_data_dir;
    w_local_req     = r_local_req;
    w_local_write   = r_local_write;
    w_local_address = r_local_address;
    w_local_size    = r_local_size;
    case (r_state)
      S_IDLE: begin
        if (!r_as_p2) begin
          w_latch    = 1'b1;
          w_state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!w_sel) begin
          w_state_nx = S_IGNORE;
        end else if (r_as_p2) begin
          w_state_nx = S_IDLE;
        end else if (r_ds_p2 != 2'b11) begin
          w_state_nx    = S_ACCESS;
          w_local_req   = 1'b1;
          w_data_oe     = 1'b0;
          w_data_dir    = !r_write;
          w_local_write = !r_write;
          // DS0 strobes the odd byte lane, DS1 the even one.
          if (!r_lword) begin
            w_local_size    = SZ_LONG;
            w_local_address = {r_addr[23:2], 2'b00};
          end else if (r_ds_p2 == 2'b00) begin
            w_local_size    = SZ_WORD;
            w_local_address = {r_addr[23:1], 1'b0};
          end else if (r_ds_p2 == 2'b10) begin
            w_local_size    = SZ_BYTE;
            w_local_address = {r_addr[23:1], 1'b1};
          end else begin
            w_local_size    = SZ_BYTE;
            w_local_address = {r_addr[23:1], 1'b0};
          end
        end
      end
      S_ACCESS: begin
        if (local_err || w_timeout) begin
          w_state_nx  = S_RESPOND;
          w_local_req = 1'b0;
          w_berr      = 1'b0;
          w_berr_oe   = 1'b1;
        end else if (local_ack) begin
          w_state_nx  = S_RESPOND;
          w_local_req = 1'b0;
          w_dtack     = 1'b0;
          w_dtack_oe  = 1'b1;
        end else if (r_as_p2) begin
          w_state_nx  = S_RELEASE;
          w_local_req = 1'b0;
          w_data_oe   = 1'b1;
        end
      end
      S_RESPOND: begin
        // Actively drive the owned line high for one clock before letting go.
        if (r_ds_p2 == 2'b11) begin
          w_state_nx = S_RELEASE;
          w_dtack    = 1'b1;
          w_berr     = 1'b1;
          w_data_oe  = 1'b1;
        end
      end
      S_RELEASE: begin
        w_dtack_oe = 1'b0;
        w_berr_oe  = 1'b0;
        if (r_as_p2) w_state_nx = S_IDLE;
      end
      S_IGNORE: begin
        if (r_as_p2) w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx  = S_IDLE;
        w_dtack_oe  = 1'b0;
        w_berr_oe   = 1'b0;
        w_local_req = 1'b0;
        w_data_oe   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_as_p1         <= 1'b1;
      r_as_p2         <= 1'b1;
      r_ds_p1         <= 2'b11;
      r_ds_p2         <= 2'b11;
      r_dtack         <= 1'b1;
      r_dtack_oe      <= 1'b0;
      r_berr          <= 1'b1;
      r_berr_oe       <= 1'b0;
      r_data_oe       <= 1'b1;
      r_data_dir      <= 1'b1;
      r_local_req     <= 1'b0;
      r_local_write   <= 1'b0;
      r_local_address <= '0;
      r_local_size    <= SZ_LONG;
    end else begin
      r_state         <= w_state_nx;
      r_as_p1         <= vme_as;
      r_as_p2         <= r_as_p1;
      r_ds_p1         <= vme_ds;
      r_ds_p2         <= r_ds_p1;
      r_dtack         <= w_dtack;
      r_dtack_oe      <= w_dtack_oe;
      r_berr          <= w_berr;
      r_berr_oe       <= w_berr_oe;
      r_data_oe       <= w_data_oe;
      r_data_dir      <= w_data_dir;
      r_local_req     <= w_local_req;
      r_local_write   <= w_local_write;
      r_local_address <= w_local_address;
      r_local_size    <= w_local_size;
    end
  end

  // Bus qualifiers are stable while AS is low, so they are captured without synchronizers.
  always_ff @(posedge clock) begin
    if (w_latch) begin
      r_addr  <= vme_address[23:1];
      r_am    <= vme_address_mod;
      r_lword <= vme_lword;
      r_write <= vme_write;
    end
  end

  assign vme_dtack     = r_dtack_oe ? r_dtack : 1'bz;
  assign vme_berr      = r_berr_oe  ? r_berr  : 1'bz;
  assign data_oe       = r_data_oe;
  assign data_dir      = r_data_dir;
  assign local_req     = r_local_req;
  assign local_write   = r_local_write;
  assign local_address = r_local_address;
  assign local_size    = r_local_size;

endmodule

// File: tb/tb_vme_slave_responder.sv
// Self-checking bench for vme_slave_responder: table-driven bus cycles with a scoreboard, plus reset/abort/re-answer sequences.
module tb_vme_slave_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        vme_as = 1'b1;
  logic [1:0]  vme_ds = 2'b11;
  logic        vme_lword = 1'b1;
  logic        vme_write = 1'b1;
  logic [5:0]  vme_address_mod = 6'h00;
  logic [23:0] vme_address = 24'h0;
  wire         w_dtack;
  wire         w_berr;
  logic        data_oe, data_dir, local_req, local_write;
  logic [23:0] local_address;
  logic [1:0]  local_size;
  logic        local_ack = 1'b0;
  logic        local_err = 1'b0;

  // Released open-collector lines float high on the backplane.
  pullup pu_dtack (w_dtack);
  pullup pu_berr (w_berr);

  vme_slave_responder #(
    .BASE_ADDR(8'h20), .ADDR_MASK(8'hF0), .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset),
    .vme_as(vme_as), .vme_ds(vme_ds), .vme_lword(vme_lword), .vme_write(vme_write),
    .vme_address_mod(vme_address_mod), .vme_address(vme_address),
    .vme_dtack(w_dtack), .vme_berr(w_berr),
    .data_oe(data_oe), .data_dir(data_dir),
    .local_req(local_req), .local_write(local_write),
    .local_address(local_address), .local_size(local_size),
    .local_ack(local_ack), .local_err(local_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  am;
    logic [23:0] addr;
    logic        lword_n;
    logic        write_n;
    logic [1:0]  ds;
    int          resp;      // 0 = ack, 1 = err, 2 = ack and err together
    logic        sel;
    logic [23:0] exp_addr;
    logic [1:0]  exp_size;
    logic        exp_wr;
    logic        exp_dir;
  } vec_t;

  typedef struct {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic        dir;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    vme_as = 1'b1; vme_ds = 2'b11; vme_lword = 1'b1; vme_write = 1'b1;
    vme_address_mod = 6'h00; vme_address = 24'h0;
  endtask

  task automatic start_cycle(input logic [5:0] am, input logic [23:0] addr,
                             input logic lw, input logic wr, input logic [1:0] ds);
    vme_address = addr; vme_address_mod = am; vme_lword = lw; vme_write = wr;
    vme_as = 1'b0; vme_ds = ds;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (local_req === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dtack"}, w_dtack, 1'b1);
    check({tag, "_berr"}, w_berr, 1'b1);
    check({tag, "_data_oe"}, data_oe, 1'b1);
    check({tag, "_data_dir"}, data_dir, 1'b1);
    check({tag, "_local_req"}, local_req, 1'b0);
    check({tag, "_local_write"}, local_write, 1'b0);
    check({tag, "_local_address"}, local_address, 24'h0);
    check({tag, "_local_size"}, local_size, 2'b00);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    bit   ok;
    bit   bad;
    start_cycle(v.am, v.addr, v.lword_n, v.write_n, v.ds);
    if (v.sel) begin
      e.addr = v.exp_addr; e.size = v.exp_size; e.wr = v.exp_wr; e.dir = v.exp_dir;
      sb.push_back(e);
      wait_req(ok);
      check($sformatf("v%0d_req_seen", idx), ok, 1'b1);
      if (ok && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("v%0d_address", idx), local_address, e.addr);
        check($sformatf("v%0d_size", idx), local_size, e.size);
        check($sformatf("v%0d_write", idx), local_write, e.wr);
        check($sformatf("v%0d_dir", idx), data_dir, e.dir);
        check($sformatf("v%0d_data_oe", idx), data_oe, 1'b0);
        check($sformatf("v%0d_dtack_idle", idx), w_dtack, 1'b1);
      end
      tick(); tick();
      local_ack = (v.resp != 1);
      local_err = (v.resp != 0);
      tick();
      local_ack = 1'b0; local_err = 1'b0;
      check($sformatf("v%0d_dtack", idx), w_dtack, (v.resp == 0) ? 1'b0 : 1'b1);
      check($sformatf("v%0d_berr", idx), w_berr, (v.resp == 0) ? 1'b1 : 1'b0);
      check($sformatf("v%0d_req_drop", idx), local_req, 1'b0);
      vme_ds = 2'b11;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
        tick();
        if (data_oe === 1'b1) ok = 1'b1;
      end
      check($sformatf("v%0d_oe_release", idx), ok, 1'b1);
      check($sformatf("v%0d_dtack_high", idx), w_dtack, 1'b1);
      check($sformatf("v%0d_berr_high", idx), w_berr, 1'b1);
      // AS still low: a second DS burst must not start another access.
      vme_ds = v.ds;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (local_req !== 1'b0 || w_dtack !== 1'b1 || w_berr !== 1'b1) bad = 1'b1;
      end
      check($sformatf("v%0d_no_reanswer", idx), bad, 1'b0);
    end else begin
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (local_req !== 1'b0 || w_dtack !== 1'b1 || w_berr !== 1'b1 || data_oe !== 1'b1) bad = 1'b1;
      end
      check($sformatf("v%0d_ignored", idx), bad, 1'b0);
    end
    bus_idle();
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    bit ok;
    bit bad;
    vecs[0] = '{6'h3D, 24'h201234, 1'b0, 1'b1, 2'b00, 0, 1'b1, 24'h201234, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{6'h39, 24'h2F0010, 1'b1, 1'b0, 2'b10, 0, 1'b1, 24'h2F0011, 2'b01, 1'b1, 1'b1};
    vecs[2] = '{6'h3A, 24'h255556, 1'b1, 1'b1, 2'b00, 0, 1'b1, 24'h255556, 2'b10, 1'b0, 1'b0};
    vecs[3] = '{6'h3E, 24'h2A0101, 1'b1, 1'b0, 2'b01, 1, 1'b1, 24'h2A0100, 2'b01, 1'b1, 1'b1};
    vecs[4] = '{6'h39, 24'h200000, 1'b1, 1'b1, 2'b10, 2, 1'b1, 24'h200001, 2'b01, 1'b0, 1'b0};
    vecs[5] = '{6'h3D, 24'h300000, 1'b0, 1'b1, 2'b00, 0, 1'b0, 24'h000000, 2'b00, 1'b0, 1'b0};
    vecs[6] = '{6'h09, 24'h201234, 1'b0, 1'b1, 2'b00, 0, 1'b0, 24'h000000, 2'b00, 1'b0, 1'b0};
    vecs[7] = '{6'h3D, 24'h2FFFFE, 1'b0, 1'b0, 2'b00, 0, 1'b1, 24'h2FFFFC, 2'b00, 1'b1, 1'b1};

    bus_idle();
    tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick(); tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    check("scoreboard_empty", sb.size(), 0);

    // Reset asserted mid-access takes effect without waiting for a clock edge.
    start_cycle(6'h3D, 24'h204000, 1'b0, 1'b0, 2'b00);
    wait_req(ok);
    check("rst_req_seen", ok, 1'b1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_mid");
    bus_idle();
    tick(); tick();
    reset = 1'b1;
    tick(); tick();

    // AS released while waiting for the local side: access is abandoned silently.
    start_cycle(6'h39, 24'h208000, 1'b1, 1'b1, 2'b00);
    wait_req(ok);
    check("abort_req_seen", ok, 1'b1);
    bus_idle();
    ok = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (local_req === 1'b0 && data_oe === 1'b1) ok = 1'b1;
      if (w_dtack !== 1'b1 || w_berr !== 1'b1) bad = 1'b1;
    end
    check("abort_req_dropped", ok, 1'b1);
    check("abort_no_dtack", bad, 1'b0);
    check("abort_oe", data_oe, 1'b1);

`ifdef VME_SLAVE_TIMEOUT_EN
    begin
      int n;
      start_cycle(6'h3D, 24'h200100, 1'b0, 1'b1, 2'b00);
      wait_req(ok);
      check("to_req_seen", ok, 1'b1);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
        tick();
        n++;
        if (w_berr === 1'b0) ok = 1'b1;
      end
      check("to_berr_seen", ok, 1'b1);
      check("to_latency", n, 4);
      check("to_dtack", w_dtack, 1'b1);
      bus_idle();
      for (int i = 0; i < 8; i++) tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
